playbus_target: RTL and testbench
=================================

PLAYBUS_TARGET -- requirements
Module: playbus_target

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset: CK2HZ clock, CLR reset.
REQ-002 The block SHALL expose these ports, clock and reset first:
- CK2HZ  input  1  system clock; all state changes on rising edge
- CLR  input  1  asynchronous active-high reset
- ADD  input  4  bus address from initiator
- n_ROMO  input  1  active-low ROM output enable
- n_RAMO  input  1  active-low RAM output enable
- n_RAMW  input  1  active-low RAM write strobe
- n_SWBEN  input  1  active-low switch buffer enable
- LEDLTCH  input  1  active-high LED latch strobe
- BUS_IN  input  8  resolved data bus value (write data)
- SW  input  8  asynchronous user switches
- BUS_OUT  output  8  read data driven toward bus
- BUS_OE  output  1  high when BUS_OUT is valid and driving
- LED  output  8  LED latch contents
- CONFLICT  output  1  sticky illegal-strobe-combination flag
- ACC_CNT  output  8  count of completed legal accesses

Function
REQ-003 All strobes, ADD and BUS_IN SHALL be sampled only on rising CK2HZ; no combinational path from inputs to outputs.
REQ-004 Read-strobe set SHALL be {n_ROMO, n_RAMO, n_SWBEN}; a cycle is a legal read when exactly one is low and n_RAMW is high.
REQ-005 On a legal read, BUS_OUT SHALL load the selected data and BUS_OE SHALL be 1 after that edge (latency 1 cycle).
REQ-006 ROM SHALL be constant: ROM[a] = {a, ~a} (e.g. ROM[3] = 8'h3C, ROM[0] = 8'h0F).
REQ-007 RAM SHALL be 16x8; RAM read returns RAM[ADD] as stored before the current edge.
REQ-008 Switch read SHALL return the SW value after a 2-flop synchronizer (data 2 cycles stale relative to SW pins).
REQ-009 When no read strobe is low, BUS_OE SHALL be 0 after the edge and BUS_OUT SHALL hold its last value.
REQ-010 A legal write is n_RAMW low with all read strobes high: RAM[ADD] SHALL load BUS_IN at that edge; a read of the same address on the next cycle SHALL return the new value.
REQ-011 Conflict = two or more read strobes low, or n_RAMW low with any read strobe low: RAM SHALL NOT be written, BUS_OE SHALL be 0 after the edge, BUS_OUT holds, CONFLICT SHALL set to 1 and remain 1 until reset.
REQ-012 LEDLTCH SHALL be edge-detected against a registered previous value: on a sampled 0->1 transition LED SHALL load BUS_IN; LEDLTCH held high SHALL NOT reload; LED latching is independent of read/write/conflict state.
REQ-013 Previous-LEDLTCH register SHALL reset to 0, so LEDLTCH high at the first edge after reset counts as a rising edge.
REQ-014 ACC_CNT SHALL increment by 1 for each edge carrying a legal read, legal write, or LED rising edge (max +1 per edge even if LED edge coincides with a read/write); wraps 255 -> 0; conflict cycles without an LED edge do not count.
REQ-015 Strobes held low across multiple edges SHALL be treated as one access per edge (re-read/re-write every cycle, counted every cycle).

Reset
REQ-016 Asserting CLR SHALL immediately force: BUS_OUT = 8'h00, BUS_OE = 0, LED = 8'h00, CONFLICT = 0, ACC_CNT = 8'h00, all RAM words = 8'h00, SW synchronizer = 8'h00, previous-LEDLTCH = 0.
REQ-017 CLR asserted mid-access SHALL abort it: no RAM write or LED load occurs at any edge while CLR is high.
REQ-018 First access SHALL be honoured at the first rising CK2HZ after CLR deasserts.

Verification
REQ-019 Reset then ADD=3, n_ROMO low one cycle -> after edge BUS_OUT=8'h3C, BUS_OE=1, ACC_CNT=1; next cycle strobes idle -> BUS_OE=0, BUS_OUT=8'h3C.
REQ-020 ADD=5, BUS_IN=8'hA5, n_RAMW low one cycle; then n_RAMO low with ADD=5 -> BUS_OUT=8'hA5; read ADD=6 -> 8'h00; ACC_CNT=3.
REQ-021 SW=8'h5A then n_SWBEN held low 3 cycles -> BUS_OUT=8'h00 after edges 1 and 2 (synchronizer reset value), 8'h5A after edge 3.
REQ-022 BUS_IN=8'hC3, LEDLTCH high 4 cycles -> LED=8'hC3 after first edge, ACC_CNT +1 only; change BUS_IN to 8'h11 while held -> LED stays 8'hC3.
REQ-023 n_ROMO and n_RAMO low together, then n_RAMW and n_RAMO low with ADD=2, BUS_IN=8'hFF -> CONFLICT=1, BUS_OE=0, RAM[2] still 8'h00, ACC_CNT unchanged; CONFLICT remains 1 through later legal reads until CLR.
REQ-024 256 consecutive legal ROM reads from reset -> ACC_CNT=8'h00 (wrap); CLR pulsed mid-write to RAM[7] -> RAM[7]=8'h00 and all outputs at reset values.

Source files
------------

// File: rtl/playbus_target.sv
// Bus target with constant ROM, 16x8 RAM, synchronized switch port and LED latch.
// Latency: reads load BUS_OUT/BUS_OE one CK2HZ edge after the strobe is sampled.
// Backpressure: none; every sampled strobe cycle is accepted or flagged as a conflict.
module playbus_target (
  input  logic       CK2HZ,
  input  logic       CLR,
  input  logic [3:0] ADD,
  input  logic       n_ROMO,
  input  logic       n_RAMO,
  input  logic       n_RAMW,
  input  logic       n_SWBEN,
  input  logic       LEDLTCH,
  input  logic [7:0] BUS_IN,
  input  logic [7:0] SW,
  output logic [7:0] BUS_OUT,
  output logic       BUS_OE,
  output logic [7:0] LED,
  output logic       CONFLICT,
  output logic [7:0] ACC_CNT
);

  logic [7:0] ram [16];
  logic [7:0] sw_meta;
  logic [7:0] sw_sync;
  logic       led_prev;
  logic [1:0] rd_low;
  logic       legal_read;
  logic       legal_write;
  logic       conflict;
  logic       led_rise;
  logic [7:0] rd_dat;

  // Decode the sampled strobe set into read/write/conflict and select read data.
  always_comb begin
    rd_low      = {1'b0, ~n_ROMO} + {1'b0, ~n_RAMO} + {1'b0, ~n_SWBEN};
    legal_read  = (rd_low == 2'd1) && n_RAMW;
    legal_write = (rd_low == 2'd0) && !n_RAMW;
    conflict    = (rd_low >= 2'd2) || (!n_RAMW && (rd_low != 2'd0));
    led_rise    = LEDLTCH && !led_prev;
    rd_dat      = 8'h00;
    if (!n_ROMO)
      rd_dat = {ADD, ~ADD};
    else if (!n_RAMO)
      rd_dat = ram[ADD];
    else if (!n_SWBEN)
      rd_dat = sw_sync;   // value before this edge's synchronizer shift
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge CK2HZ or posedge CLR) begin
    if (CLR) begin
      sw_meta <= 8'h00;
      sw_sync <= 8'h00;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  // RAM storage; only a legal write updates it, a conflict never does.
  always_ff @(posedge CK2HZ or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < 16; i++)
        ram[i] <= 8'h00;
    end else if (legal_write) begin
      ram[ADD] <= BUS_IN;
    end
  end

  // Read data path: load on a legal read, otherwise hold data and release the bus.
  always_ff @(posedge CK2HZ or posedge CLR) begin
    if (CLR) begin
      BUS_OUT <= 8'h00;
      BUS_OE  <= 1'b0;
    end else begin
      BUS_OE <= legal_read;
      if (legal_read)
        BUS_OUT <= rd_dat;
    end
  end

  // LED latch on a sampled rising edge of LEDLTCH, independent of bus activity.
  always_ff @(posedge CK2HZ or posedge CLR) begin
    if (CLR) begin
      led_prev <= 1'b0;
      LED      <= 8'h00;
    end else begin
      led_prev <= LEDLTCH;
      if (led_rise)
        LED <= BUS_IN;
    end
  end

  // Sticky conflict flag and wrapping access counter (at most +1 per edge).
  always_ff @(posedge CK2HZ or posedge CLR) begin
    if (CLR) begin
      CONFLICT <= 1'b0;
      ACC_CNT  <= 8'h00;
    end else begin
      if (conflict)
        CONFLICT <= 1'b1;
      if (legal_read || legal_write || led_rise)
        ACC_CNT <= ACC_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_playbus_target.sv
// Directed self-checking bench for playbus_target.
// Inputs change 1 ns after each rising edge; outputs are checked at the same point.
// Expected values are hand-computed constants per step.
module tb_playbus_target;

  logic       CK2HZ = 1'b0;
  logic       CLR;
  logic [3:0] ADD;
  logic       n_ROMO, n_RAMO, n_RAMW, n_SWBEN, LEDLTCH;
  logic [7:0] BUS_IN, SW;
  logic [7:0] BUS_OUT, LED, ACC_CNT;
  logic       BUS_OE, CONFLICT;

  int tests = 0;
  int fails = 0;

  playbus_target dut (
    .CK2HZ   (CK2HZ),
    .CLR     (CLR),
    .ADD     (ADD),
    .n_ROMO  (n_ROMO),
    .n_RAMO  (n_RAMO),
    .n_RAMW  (n_RAMW),
    .n_SWBEN (n_SWBEN),
    .LEDLTCH (LEDLTCH),
    .BUS_IN  (BUS_IN),
    .SW      (SW),
    .BUS_OUT (BUS_OUT),
    .BUS_OE  (BUS_OE),
    .LED     (LED),
    .CONFLICT(CONFLICT),
    .ACC_CNT (ACC_CNT)
  );

  always #5 CK2HZ = ~CK2HZ;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CK2HZ);
    #1;
  endtask

  task automatic idle();
    n_ROMO  = 1'b1;
    n_RAMO  = 1'b1;
    n_RAMW  = 1'b1;
    n_SWBEN = 1'b1;
    LEDLTCH = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
  endtask

  initial begin
    ADD = 4'h0; BUS_IN = 8'h00; SW = 8'h00;
    idle();
    CLR = 1'b1;
    #1;
    chk("rst_bus_out", BUS_OUT, 8'h00);
    chk("rst_oe",      {7'd0, BUS_OE}, 8'h00);
    chk("rst_led",     LED, 8'h00);
    chk("rst_conflict",{7'd0, CONFLICT}, 8'h00);
    chk("rst_acc",     ACC_CNT, 8'h00);
    step();
    CLR = 1'b0;

    // ROM read at address 3, then idle
    ADD = 4'h3; n_ROMO = 1'b0;
    step();
    chk("rom3_data", BUS_OUT, 8'h3C);
    chk("rom3_oe",   {7'd0, BUS_OE}, 8'h01);
    chk("rom3_acc",  ACC_CNT, 8'h01);
    idle();
    step();
    chk("idle_oe",   {7'd0, BUS_OE}, 8'h00);
    chk("idle_hold", BUS_OUT, 8'h3C);
    ADD = 4'h0; n_ROMO = 1'b0;
    step();
    chk("rom0_data", BUS_OUT, 8'h0F);

    // RAM write then read-back
    do_reset();
    ADD = 4'h5; BUS_IN = 8'hA5; n_RAMW = 1'b0;
    step();
    chk("wr_oe", {7'd0, BUS_OE}, 8'h00);
    idle(); n_RAMO = 1'b0;
    step();
    chk("ram5_data", BUS_OUT, 8'hA5);
    ADD = 4'h6;
    step();
    chk("ram6_data", BUS_OUT, 8'h00);
    chk("ram_acc",   ACC_CNT, 8'h03);

    // Switch read through the synchronizer
    do_reset();
    SW = 8'h5A; n_SWBEN = 1'b0;
    step();
    chk("sw_edge1", BUS_OUT, 8'h00);
    step();
    chk("sw_edge2", BUS_OUT, 8'h00);
    step();
    chk("sw_edge3", BUS_OUT, 8'h5A);
    chk("sw_acc",   ACC_CNT, 8'h03);

    // LED latch: first edge after reset counts as rising
    do_reset();
    idle();
    BUS_IN = 8'hC3; LEDLTCH = 1'b1;
    step();
    chk("led_first", LED, 8'hC3);
    chk("led_acc1",  ACC_CNT, 8'h01);
    BUS_IN = 8'h11;
    step(); step(); step();
    chk("led_held",     LED, 8'hC3);
    chk("led_held_acc", ACC_CNT, 8'h01);
    LEDLTCH = 1'b0;
    step();
    LEDLTCH = 1'b1; BUS_IN = 8'h77; ADD = 4'h1; n_ROMO = 1'b0;
    step();
    chk("led_with_read", LED, 8'h77);
    chk("rom1_data",     BUS_OUT, 8'h1E);
    chk("led_read_acc",  ACC_CNT, 8'h02);

    // Conflicts
    do_reset();
    ADD = 4'h3; n_ROMO = 1'b0;
    step();
    n_RAMO = 1'b0;
    step();
    chk("cf1_flag", {7'd0, CONFLICT}, 8'h01);
    chk("cf1_oe",   {7'd0, BUS_OE}, 8'h00);
    chk("cf1_hold", BUS_OUT, 8'h3C);
    chk("cf1_acc",  ACC_CNT, 8'h01);
    idle();
    ADD = 4'h2; BUS_IN = 8'hFF; n_RAMW = 1'b0; n_RAMO = 1'b0;
    step();
    chk("cf2_flag", {7'd0, CONFLICT}, 8'h01);
    chk("cf2_acc",  ACC_CNT, 8'h01);
    idle(); n_RAMO = 1'b0;
    step();
    chk("cf_ram2",    BUS_OUT, 8'h00);
    chk("cf_sticky",  {7'd0, CONFLICT}, 8'h01);
    chk("cf_rd_acc",  ACC_CNT, 8'h02);
    do_reset();
    chk("cf_cleared", {7'd0, CONFLICT}, 8'h00);

    // Counter wrap after 256 legal reads
    ADD = 4'h3; n_ROMO = 1'b0;
    for (int i = 0; i < 255; i++) step();
    chk("acc_255", ACC_CNT, 8'hFF);
    step();
    chk("acc_wrap", ACC_CNT, 8'h00);

    // Reset aborts a write in progress
    idle();
    ADD = 4'h7; BUS_IN = 8'h99; n_RAMW = 1'b0; LEDLTCH = 1'b1;
    #2;
    CLR = 1'b1;
    #1;
    chk("abort_bus_out", BUS_OUT, 8'h00);
    chk("abort_acc",     ACC_CNT, 8'h00);
    step(); step();
    chk("abort_led",     LED, 8'h00);
    chk("abort_acc2",    ACC_CNT, 8'h00);
    idle(); ADD = 4'h7; n_RAMO = 1'b0;
    CLR = 1'b0;
    BUS_OUT_first_edge: begin
      step();
      chk("post_rst_oe",  {7'd0, BUS_OE}, 8'h01);
      chk("post_rst_r7",  BUS_OUT, 8'h00);
      chk("post_rst_acc", ACC_CNT, 8'h01);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
